// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 8-bit ALU among NUM_REQ requesters.
// A round-robin arbiter picks one pending request, drives it onto the ALU bus,
// waits ALU_LAT cycles, captures the 16-bit result and hands it back to the
// owner over a response handshake. Only one operation is ever in flight.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_a, req_b, req_s   packed per-requester operands / opcode
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_data              captured ALU result, shared by all requesters
//   alu_a, alu_b, alu_s   registered ALU operand / opcode bus
//   alu_out               ALU result
//   busy                  high whenever not idle
//   grant_id              index of the current or last owner
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_a,
    input  logic [8*NUM_REQ-1:0]       req_b,
    input  logic [4*NUM_REQ-1:0]       req_s,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [15:0]                rsp_data,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    output logic [3:0]                 alu_s,
    input  logic [15:0]                alu_out,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned SumW = IdW + 1;
    localparam int unsigned CntW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q;
    logic [IdW-1:0]     last_q;
    logic [IdW-1:0]     grant_id_q;
    logic [7:0]         alu_a_q, alu_b_q;
    logic [3:0]         alu_s_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [15:0]        rsp_data_q;
    logic               busy_q;

    logic               found;
    logic [IdW-1:0]     win;
    logic [SumW-1:0]    sum;
    logic [7:0]         sel_a, sel_b;
    logic [3:0]         sel_s;
    logic               accept;

    // Round-robin search starting just after the last owner, wrapping back to it.
    // The sum is one bit wider so last+k never overflows before the wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_q} + SumW'(k);
            if (sum >= SumW'(NUM_REQ)) begin
                sum = sum - SumW'(NUM_REQ);
            end
            if (!found && req_valid[sum[IdW-1:0]]) begin
                found = 1'b1;
                win   = sum[IdW-1:0];
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == IdW'(i)) begin
                sel_a = req_a[8*i +: 8];
                sel_b = req_b[8*i +: 8];
                sel_s = req_s[4*i +: 4];
            end
        end
    end

    // Next state and request handshake. req_ready is forced low while reset is held.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            StIdle: begin
                if (found && rst_n) begin
                    accept         = 1'b1;
                    req_ready[win] = 1'b1;
                    state_d        = StExec;
                end
            end
            StExec: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready[grant_id_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_q      <= IdW'(NUM_REQ - 1);
            grant_id_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            if (accept) begin
                alu_a_q    <= sel_a;
                alu_b_q    <= sel_b;
                alu_s_q    <= sel_s;
                grant_id_q <= win;
                last_q     <= win;
                cnt_q      <= CntW'(ALU_LAT);
            end
            if (state_q == StExec) begin
                cnt_q <= cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    rsp_data_q              <= alu_out;
                    rsp_valid_q[grant_id_q] <= 1'b1;
                end
            end
            if ((state_q == StResp) && rsp_ready[grant_id_q]) begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule
